// File: rtl/systolic_edge_feeder_if.sv
// Vector input stream into the systolic edge feeder: producer (master) to feeder (slave).
interface systolic_edge_feeder_if #(
  parameter int WORD_SIZE = 16,
  parameter int NUM_ROWS  = 4
);
  logic                          in_valid;
  logic                          in_ready;
  logic [NUM_ROWS*WORD_SIZE-1:0] in_data;
  logic                          in_last;

  modport master (output in_valid, output in_data, output in_last, input  in_ready);
  modport slave  (input  in_valid, input  in_data, input  in_last, output in_ready);
endinterface

// File: rtl/systolic_edge_feeder.sv
// Buffers operand vectors in a FIFO and injects them into the array west edge with
// diagonal skew: lane r lags lane 0 by r cycles. tile_done marks the final skewed word.
//
//   state  | meaning
//   IDLE   | waiting for start, FIFO may fill
//   STREAM | popping one vector per cycle, bubbles when FIFO empty
//   DRAIN  | last vector popped, waiting for its top lane to leave
module systolic_edge_feeder #(
  parameter int WORD_SIZE  = 16,
  parameter int NUM_ROWS   = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  systolic_edge_feeder_if.slave                 in_if,
  output logic [NUM_ROWS*WORD_SIZE-1:0]         edge_out,
  output logic [NUM_ROWS-1:0]                   edge_valid,
  output logic                                  tile_done,
  output logic                                  busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]       fifo_count
);
  localparam int VW = NUM_ROWS * WORD_SIZE;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int DW = $clog2(NUM_ROWS);

  typedef enum logic [1:0] {ST_IDLE, ST_STREAM, ST_DRAIN} state_t;

  state_t          state_q, state_d;
  logic [VW:0]     mem_q [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [DW-1:0]   drain_q, drain_d;
  logic            tile_done_q, tile_done_d;
  logic            push;
  logic            pop;
  logic [VW:0]     head;

  // Ready depends only on the registered count, so a same-cycle pop never frees a slot.
  assign in_if.in_ready = rst && (count_q < CW'(FIFO_DEPTH));
  assign push           = in_if.in_valid && in_if.in_ready;
  assign pop            = (state_q == ST_STREAM) && (count_q != '0);
  assign head           = mem_q[rd_ptr_q];

  always_comb begin
    state_d     = state_q;
    drain_d     = drain_q;
    tile_done_d = 1'b0;
    wr_ptr_d    = wr_ptr_q + PW'(push);
    rd_ptr_d    = rd_ptr_q + PW'(pop);
    count_d     = count_q + CW'(push) - CW'(pop);
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_STREAM;
      end
      ST_STREAM: begin
        if (pop && head[VW]) begin
          state_d = ST_DRAIN;
          drain_d = DW'(NUM_ROWS - 1);
        end
      end
      ST_DRAIN: begin
        if (drain_q == '0) begin
          state_d     = ST_IDLE;
          tile_done_d = 1'b1;
        end else begin
          drain_d = drain_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      drain_q     <= '0;
      tile_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      drain_q     <= drain_d;
      tile_done_q <= tile_done_d;
    end
  end

  // Storage needs no reset: emptiness is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_if.in_last, in_if.in_data};
  end

  // Each lane is a {valid, word} delay line of depth r+1; bubbles enter as all-zero.
  for (genvar r = 0; r < NUM_ROWS; r++) begin : g_lane
    logic [WORD_SIZE:0] dly_q [0:r];
    logic [WORD_SIZE:0] dly_d [0:r];

    always_comb begin
      dly_d[0] = pop ? {1'b1, head[r*WORD_SIZE +: WORD_SIZE]} : '0;
      for (int k = 1; k <= r; k++) dly_d[k] = dly_q[k-1];
    end

    always_ff @(posedge clk) begin
      if (!rst) begin
        for (int k = 0; k <= r; k++) dly_q[k] <= '0;
      end else begin
        for (int k = 0; k <= r; k++) dly_q[k] <= dly_d[k];
      end
    end

    assign edge_out[r*WORD_SIZE +: WORD_SIZE] = dly_q[r][WORD_SIZE-1:0];
    assign edge_valid[r]                      = dly_q[r][WORD_SIZE];
  end

  assign tile_done  = tile_done_q;
  assign busy       = (state_q != ST_IDLE);
  assign fifo_count = count_q;
endmodule

// File: tb/tb_systolic_edge_feeder.sv
// Directed bench for systolic_edge_feeder: reset, skew timing, FIFO full, bubbles, reset in DRAIN.
module tb_systolic_edge_feeder;
  localparam int WS = 16;
  localparam int NR = 4;
  localparam int FD = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           start = 1'b0;
  logic [NR*WS-1:0] edge_out;
  logic [NR-1:0]  edge_valid;
  logic           tile_done;
  logic           busy;
  logic [3:0]     fifo_count;
  int             n_cmp = 0;
  int             n_mis = 0;

  systolic_edge_feeder_if #(.WORD_SIZE(WS), .NUM_ROWS(NR)) in_if ();

  systolic_edge_feeder #(.WORD_SIZE(WS), .NUM_ROWS(NR), .FIFO_DEPTH(FD)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_if      (in_if.slave),
    .edge_out   (edge_out),
    .edge_valid (edge_valid),
    .tile_done  (tile_done),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NR*WS-1:0] vec(input logic [WS-1:0] base);
    logic [NR*WS-1:0] v;
    for (int r = 0; r < NR; r++) v[r*WS +: WS] = base + WS'(r);
    return v;
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    in_if.in_valid = 1'b1;
    in_if.in_data  = vec(16'h5500);
    in_if.in_last  = 1'b0;
    repeat (3) tick();
    if (in_if.in_ready !== 1'b0) begin $display("FAIL reset_in_ready got=%b exp=0", in_if.in_ready); n_mis++; end n_cmp++;
    if (edge_valid !== 4'b0) begin $display("FAIL reset_edge_valid got=%b exp=0000", edge_valid); n_mis++; end n_cmp++;
    if (fifo_count !== 4'd0) begin $display("FAIL reset_count got=%0d exp=0", fifo_count); n_mis++; end n_cmp++;
    if (busy !== 1'b0) begin $display("FAIL reset_busy got=%b exp=0", busy); n_mis++; end n_cmp++;
    if (tile_done !== 1'b0) begin $display("FAIL reset_tile_done got=%b exp=0", tile_done); n_mis++; end n_cmp++;
    if (edge_out !== '0) begin $display("FAIL reset_edge_out got=%h exp=0", edge_out); n_mis++; end n_cmp++;
    in_if.in_valid = 1'b0;
    rst = 1'b1;
    tick();
    if (fifo_count !== 4'd0) begin $display("FAIL reset_release_count got=%0d exp=0", fifo_count); n_mis++; end n_cmp++;
  endtask

  task automatic test_single_tile();
    logic [NR*WS-1:0] e;
    in_if.in_valid = 1'b1;
    in_if.in_data  = vec(16'd1);
    in_if.in_last  = 1'b1;
    tick();
    if (fifo_count !== 4'd1) begin $display("FAIL t2_count_push got=%0d exp=1", fifo_count); n_mis++; end n_cmp++;
    in_if.in_valid = 1'b0;
    in_if.in_last  = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    if (busy !== 1'b1) begin $display("FAIL t2_busy_pop got=%b exp=1", busy); n_mis++; end n_cmp++;
    if (edge_valid !== 4'b0) begin $display("FAIL t2_valid_pop got=%b exp=0000", edge_valid); n_mis++; end n_cmp++;
    for (int k = 1; k <= 6; k++) begin
      tick();
      e = '0;
      if (k <= NR) e[(k-1)*WS +: WS] = WS'(k);
      if (edge_out !== e) begin $display("FAIL t2_edge_out P+%0d got=%h exp=%h", k, edge_out, e); n_mis++; end n_cmp++;
      if (edge_valid !== ((k <= NR) ? 4'(1 << (k-1)) : 4'b0)) begin
        $display("FAIL t2_edge_valid P+%0d got=%b", k, edge_valid); n_mis++;
      end n_cmp++;
      if (tile_done !== (k == 5)) begin $display("FAIL t2_tile_done P+%0d got=%b exp=%b", k, tile_done, (k == 5)); n_mis++; end n_cmp++;
      if (busy !== (k <= 4)) begin $display("FAIL t2_busy P+%0d got=%b exp=%b", k, busy, (k <= 4)); n_mis++; end n_cmp++;
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 9; i++) begin
      in_if.in_valid = 1'b1;
      in_if.in_data  = vec(WS'((i + 1) << 8));
      in_if.in_last  = 1'b0;
      if (in_if.in_ready !== (i < FD)) begin $display("FAIL t3_ready i=%0d got=%b exp=%b", i, in_if.in_ready, (i < FD)); n_mis++; end n_cmp++;
      tick();
    end
    in_if.in_valid = 1'b0;
    if (fifo_count !== 4'd8) begin $display("FAIL t3_count got=%0d exp=8", fifo_count); n_mis++; end n_cmp++;
    if (busy !== 1'b0) begin $display("FAIL t3_busy got=%b exp=0", busy); n_mis++; end n_cmp++;
  endtask

  task automatic test_full_pop();
    int waited;
    start = 1'b1;
    in_if.in_valid = 1'b1;
    in_if.in_data  = vec(16'hA000);
    in_if.in_last  = 1'b1;
    if (in_if.in_ready !== 1'b0) begin $display("FAIL t4_ready_full got=%b exp=0", in_if.in_ready); n_mis++; end n_cmp++;
    tick();
    start = 1'b0;
    if (fifo_count !== 4'd8) begin $display("FAIL t4_count_pop got=%0d exp=8", fifo_count); n_mis++; end n_cmp++;
    if (in_if.in_ready !== 1'b0) begin $display("FAIL t4_ready_pop got=%b exp=0", in_if.in_ready); n_mis++; end n_cmp++;
    tick();
    if (fifo_count !== 4'd7) begin $display("FAIL t4_count_after_pop got=%0d exp=7", fifo_count); n_mis++; end n_cmp++;
    if (in_if.in_ready !== 1'b1) begin $display("FAIL t4_ready_after_pop got=%b exp=1", in_if.in_ready); n_mis++; end n_cmp++;
    if (edge_valid[0] !== 1'b1 || edge_out[WS-1:0] !== 16'h0100) begin
      $display("FAIL t4_lane0_first got=%b/%h exp=1/0100", edge_valid[0], edge_out[WS-1:0]); n_mis++;
    end n_cmp++;
    tick();
    in_if.in_valid = 1'b0;
    in_if.in_last  = 1'b0;
    if (fifo_count !== 4'd7) begin $display("FAIL t4_count_push_pop got=%0d exp=7", fifo_count); n_mis++; end n_cmp++;
    if (edge_out[WS-1:0] !== 16'h0200) begin $display("FAIL t4_lane0_second got=%h exp=0200", edge_out[WS-1:0]); n_mis++; end n_cmp++;
    waited = 0;
    while (tile_done !== 1'b1 && waited < 40) begin
      tick();
      waited++;
    end
    if (waited !== 11) begin $display("FAIL t4_tile_done_delay got=%0d exp=11", waited); n_mis++; end n_cmp++;
    tick();
    if (tile_done !== 1'b0) begin $display("FAIL t4_tile_done_pulse got=%b exp=0", tile_done); n_mis++; end n_cmp++;
    if (busy !== 1'b0 || fifo_count !== 4'd0) begin
      $display("FAIL t4_end_state got=busy %b count %0d exp=busy 0 count 0", busy, fifo_count); n_mis++;
    end n_cmp++;
  endtask

  task automatic test_bubbles();
    logic [NR*WS-1:0] e;
    logic [NR-1:0]    ev;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      e  = '0;
      ev = '0;
      for (int r = 0; r < NR; r++) begin
        if (k == 3 + r) begin e[r*WS +: WS] = 16'hA0A0 + WS'(r); ev[r] = 1'b1; end
        if (k == 6 + r) begin e[r*WS +: WS] = 16'hB0B0 + WS'(r); ev[r] = 1'b1; end
      end
      if (edge_out !== e) begin $display("FAIL t5_edge_out S+%0d got=%h exp=%h", k, edge_out, e); n_mis++; end n_cmp++;
      if (edge_valid !== ev) begin $display("FAIL t5_edge_valid S+%0d got=%b exp=%b", k, edge_valid, ev); n_mis++; end n_cmp++;
      if (tile_done !== (k == 10)) begin $display("FAIL t5_tile_done S+%0d got=%b exp=%b", k, tile_done, (k == 10)); n_mis++; end n_cmp++;
      in_if.in_valid = (k == 1) || (k == 4);
      in_if.in_data  = (k == 1) ? vec(16'hA0A0) : vec(16'hB0B0);
      in_if.in_last  = (k == 4);
      tick();
    end
    in_if.in_valid = 1'b0;
    in_if.in_last  = 1'b0;
    if (busy !== 1'b0) begin $display("FAIL t5_busy_end got=%b exp=0", busy); n_mis++; end n_cmp++;
  endtask

  task automatic test_reset_drain();
    in_if.in_valid = 1'b1;
    in_if.in_data  = vec(16'hC0C0);
    in_if.in_last  = 1'b1;
    tick();
    in_if.in_valid = 1'b0;
    in_if.in_last  = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    if (busy !== 1'b1) begin $display("FAIL t6_busy_drain got=%b exp=1", busy); n_mis++; end n_cmp++;
    tick();
    if (edge_valid !== 4'b0010) begin $display("FAIL t6_valid_drain got=%b exp=0010", edge_valid); n_mis++; end n_cmp++;
    rst = 1'b0;
    tick();
    if (edge_out !== '0) begin $display("FAIL t6_edge_out got=%h exp=0", edge_out); n_mis++; end n_cmp++;
    if (edge_valid !== 4'b0) begin $display("FAIL t6_edge_valid got=%b exp=0000", edge_valid); n_mis++; end n_cmp++;
    if (busy !== 1'b0) begin $display("FAIL t6_busy got=%b exp=0", busy); n_mis++; end n_cmp++;
    if (fifo_count !== 4'd0) begin $display("FAIL t6_count got=%0d exp=0", fifo_count); n_mis++; end n_cmp++;
    if (in_if.in_ready !== 1'b0) begin $display("FAIL t6_in_ready got=%b exp=0", in_if.in_ready); n_mis++; end n_cmp++;
    rst = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (tile_done !== 1'b0 || edge_valid !== 4'b0) begin
        $display("FAIL t6_quiet k=%0d got=done %b valid %b exp=done 0 valid 0000", k, tile_done, edge_valid); n_mis++;
      end n_cmp++;
      tick();
    end
  endtask

  initial begin
    in_if.in_valid = 1'b0;
    in_if.in_data  = '0;
    in_if.in_last  = 1'b0;
    test_reset();
    test_single_tile();
    test_fill();
    test_full_pop();
    test_bubbles();
    test_reset_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
